booth_mult_n: RTL and testbench

BOOTH_MULT_N -- requirements
Module: booth_mult_n

---
 rtl/booth_pkg.sv | 5 +
 rtl/booth_mult_n_dp.sv | 42 ++++
 rtl/booth_mult_n.sv | 46 ++++
 tb/tb_booth_mult_n.sv | 129 ++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM state encoding and default operand width for the Booth multiplier
package booth_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/booth_mult_n_dp.sv
// booth_mult_n_dp: radix-2 Booth datapath holding M, A, Q, Q(-1) with one add/sub-and-shift step per cycle
module booth_mult_n_dp import booth_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic               add,
  input  logic               sub,
  input  logic               sh,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               q0,
  output logic               qm1,
  output logic [2*WIDTH-1:0] prod
);
  localparam int W1 = WIDTH + 1;
  logic [W1-1:0] m, q;
  logic [W1:0]   acc, m_x, sum;
  logic          qm;
  assign m_x  = {m[W1-1], m};
  assign sum  = add ? acc + m_x : sub ? acc - m_x : acc;
  assign q0   = q[0];
  assign qm1  = qm;
  assign prod = {acc[WIDTH-2:0], q};
  // the extra top bit of each operand makes unsigned values positive in the signed algorithm
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      m   <= '0;
      q   <= '0;
      acc <= '0;
      qm  <= 1'b0;
    end else if (ld) begin
      m   <= {signed_mode & a[WIDTH-1], a};
      q   <= {signed_mode & b[WIDTH-1], b};
      acc <= '0;
      qm  <= 1'b0;
    end else if (sh) begin
      {acc, q, qm} <= {sum[W1], sum, q};
    end
endmodule

// File: rtl/booth_mult_n.sv
// booth_mult_n: sequential radix-2 Booth multiplier with signed/unsigned mode and fixed WIDTH+3 latency
module booth_mult_n import booth_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 2);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] prod;
  logic q0, qm1, run_op, accept;
  assign ready  = (state == IDLE) || (state == DONE);
  assign busy   = (state == LOAD) || (state == RUN);
  assign done   = (state == DONE);
  assign accept = ready & start;
  assign run_op = (state == RUN) && (cnt != '0);
  always_comb
    nxt = (state == LOAD) ? RUN :
          (state == RUN)  ? ((cnt == '0) ? DONE : RUN) :
          (start ? LOAD : IDLE);
  // operands are captured at acceptance so changes while busy cannot leak in
  booth_mult_n_dp #(.WIDTH(WIDTH)) u_dp (
    .clk(clk), .rst(rst), .ld(accept), .add(run_op & ~q0 & qm1), .sub(run_op & q0 & ~qm1),
    .sh(run_op), .signed_mode(signed_mode), .a(a), .b(b), .q0(q0), .qm1(qm1), .prod(prod)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= nxt;
      if (state == LOAD) cnt <= CW'(WIDTH + 1);
      else if (run_op) cnt <= cnt - 1'b1;
      if (state == RUN && cnt == '0) product <= prod;
    end
endmodule

// File: tb/tb_booth_mult_n.sv
// tb_booth_mult_n: randomized scoreboard bench comparing the Booth multiplier against plain integer multiplication
module tb_booth_mult_n;
  localparam int W = 8;
  typedef struct {logic [2*W-1:0] p; int c;} exp_t;
  logic clk = 0, rst = 0, start = 0, signed_mode = 0;
  logic [W-1:0] a = '0, b = '0;
  logic ready, busy, done;
  logic [2*W-1:0] product;
  logic [2*W-1:0] last_p = '0;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;

  booth_mult_n #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] model(bit sm, logic [W-1:0] x, logic [W-1:0] y);
    longint sx, sy;
    logic [63:0] r;
    sx = sm ? longint'($signed(x)) : longint'({1'b0, x});
    sy = sm ? longint'($signed(y)) : longint'({1'b0, y});
    r = 64'(sx * sy);
    return r[2*W-1:0];
  endfunction

  task automatic chk(string n, logic [63:0] act, logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", n, act, want, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) last_p = '0;
    else if (done) begin
      if (q.size() == 0) chk("done_unexpected", done, 0);
      else begin
        e = q.pop_front();
        chk("product", product, e.p);
        chk("latency", cyc, e.c);
        last_p = e.p;
      end
    end else if (product !== last_p) chk("product_hold", product, last_p);
  end

  task automatic issue(bit sm, logic [W-1:0] x, logic [W-1:0] y);
    signed_mode = sm; a = x; b = y; start = 1;
    @(posedge clk); #1;
    q.push_back('{p: model(sm, x, y), c: cyc + W + 3});
    start = 0;
  endtask

  task automatic go(bit sm, logic [W-1:0] x, logic [W-1:0] y);
    @(negedge clk);
    chk("ready_idle", ready, 1);
    issue(sm, x, y);
    @(negedge clk);
    chk("busy_load", busy, 1);
    chk("ready_load", ready, 0);
  endtask

  task automatic settle();
    repeat (W + 4) @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 40);
    chk("done_seen", done, 1);
  endtask

  initial begin
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    @(negedge clk); #2 rst = 1;
    go(1, 8'h80, 8'h80); settle();
    go(0, 8'hFF, 8'hFF); settle();
    go(1, 8'hFF, 8'hFF); settle();
    go(1, 8'hFF, 8'h01); settle();
    go(1, 8'h00, 8'h7F); settle();
    go(1, 8'h7F, 8'h80); settle();
    go(0, 8'h12, 8'h34);
    repeat (3) @(negedge clk);
    chk("busy_run", busy, 1);
    signed_mode = 1; a = 8'h80; b = 8'h7F; start = 1;
    @(posedge clk); #1 start = 0;
    a = 8'hAA; b = 8'h55;
    settle(); settle();
    go(1, 8'h81, 8'h05);
    wait_done();
    issue(0, 8'd3, 8'd5);
    chk("b2b_busy", busy, 1);
    wait_done();
    @(negedge clk);
    chk("b2b_idle_ready", ready, 1);
    go(1, 8'h55, 8'h66);
    repeat (5) @(posedge clk);
    #2 rst = 0;
    #1;
    chk("arst_ready", ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_product", product, 0);
    q.delete();
    @(negedge clk); #3 rst = 1;
    go(0, 8'd7, 8'd6); settle();
    for (int i = 0; i < 40; i++) begin
      go(1'($urandom_range(1)), 8'($urandom), 8'($urandom));
      if ($urandom_range(2) == 0) begin
        wait_done();
        issue(1'($urandom_range(1)), 8'($urandom), 8'($urandom));
      end
      settle();
    end
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
